// File: rtl/pipes_pkg.sv
// Shared types and constants for the pipe game datapath: game states,
// LFSR taps/seed and screen geometry.
package pipes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int GROUND_Y = 428;

endpackage

// File: rtl/pipe_lfsr.sv
// 16-bit Fibonacci LFSR, free-running every clock, used as the gap height source.
module pipe_lfsr
    import pipes_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] lfsr
);

    always_ff @(posedge clk) begin
        if (!rst_n) lfsr <= SEED;
        else        lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end

endmodule

// File: rtl/pipe_scheduler.sv
// Game-level sequencer: game-state FSM, movement step timer, two pipe slots
// with random gap regeneration on wrap, and the saturating pass score.
module pipe_scheduler
    import pipes_pkg::*;
#(
    parameter int          STEP_DIV     = 65536,
    parameter int          WRAP_X       = 640,
    parameter int          INIT_X0      = 960,
    parameter int          PIPE_SPACING = 320,
    parameter int          SCORE_X      = 100,
    parameter int          GAP_MIN      = 40,
    parameter int          GAP_BITS     = 7,
    parameter logic [15:0] LFSR_SEED    = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        Button,
    input  logic        Collision,
    output logic [15:0] PipeX0,
    output logic [15:0] PipeX1,
    output logic [15:0] GapY0,
    output logic [15:0] GapY1,
    output logic        Status,
    output logic        GameOver,
    output logic [7:0]  Score,
    output logic        StepTick
);

    localparam int          DW       = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(STEP_DIV - 1);
    localparam logic [15:0] X0_INIT  = 16'(INIT_X0);
    localparam logic [15:0] X1_INIT  = 16'(INIT_X0 + PIPE_SPACING);
    localparam logic [15:0] X_WRAP   = 16'(WRAP_X);
    localparam logic [15:0] X_SCORE  = 16'(SCORE_X);
    localparam logic [15:0] GAP_BASE = 16'(GAP_MIN);
    localparam logic [15:0] GAP_MASK = 16'((1 << GAP_BITS) - 1);

    state_t        state, state_nx;
    logic [2:0]    btn_q;
    logic          press;
    logic [15:0]   lfsr, gap;
    logic [DW-1:0] div;
    logic          move;
    logic          wrap0, wrap1, wrap_both;
    logic [15:0]   nx0, nx1;
    logic [1:0]    hits;
    logic [8:0]    score_sum;
    logic [7:0]    score_sat;
    logic          slot1_pend, slot1_wrap;

    pipe_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (Reset),
        .lfsr  (lfsr)
    );

    // btn_q[1:0] synchronise the pin, btn_q[2] remembers the previous level.
    assign press = btn_q[2] & ~btn_q[1];
    assign gap   = GAP_BASE + (lfsr & GAP_MASK);

    assign StepTick  = (state == RUN) && (div == DIV_MAX);
    assign move      = StepTick && !Collision;
    assign wrap0     = (PipeX0 == 16'd0);
    assign wrap1     = (PipeX1 == 16'd0);
    assign wrap_both = wrap0 && wrap1;
    assign nx0       = wrap0 ? X_WRAP : PipeX0 - 16'd1;
    // On a double wrap slot 1 holds at 0 for one cycle and reloads afterwards.
    assign nx1       = wrap_both ? PipeX1 : (wrap1 ? X_WRAP : PipeX1 - 16'd1);
    assign hits      = {1'b0, nx0 == X_SCORE} + {1'b0, nx1 == X_SCORE};
    assign score_sum = {1'b0, Score} + {7'd0, hits};
    assign score_sat = score_sum[8] ? 8'hFF : score_sum[7:0];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (press)     state_nx = RUN;
            RUN:     if (Collision) state_nx = DEAD;
            DEAD:    if (press)     state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state      <= IDLE;
            btn_q      <= 3'b111;
            div        <= '0;
            PipeX0     <= X0_INIT;
            PipeX1     <= X1_INIT;
            GapY0      <= GAP_BASE;
            GapY1      <= GAP_BASE;
            Score      <= 8'd0;
            Status     <= 1'b0;
            GameOver   <= 1'b0;
            slot1_pend <= 1'b0;
            slot1_wrap <= 1'b0;
        end else begin
            btn_q      <= {btn_q[1:0], Button};
            state      <= state_nx;
            Status     <= (state == RUN);
            GameOver   <= (state == DEAD);
            slot1_pend <= 1'b0;
            slot1_wrap <= 1'b0;

            // Deferred slot 1 load: takes the gap value one cycle after slot 0.
            if (slot1_pend) begin
                GapY1 <= gap;
                if (slot1_wrap) PipeX1 <= X_WRAP;
            end

            case (state)
                IDLE: begin
                    if (press) begin
                        GapY0      <= gap;
                        slot1_pend <= 1'b1;
                        div        <= '0;
                    end
                end
                RUN: begin
                    if (!Collision) div <= (div == DIV_MAX) ? '0 : div + DW'(1);
                    if (move) begin
                        PipeX0 <= nx0;
                        PipeX1 <= nx1;
                        Score  <= score_sat;
                        if (wrap0) GapY0 <= gap;
                        if (wrap_both) begin
                            slot1_pend <= 1'b1;
                            slot1_wrap <= 1'b1;
                        end else if (wrap1) begin
                            GapY1 <= gap;
                        end
                    end
                end
                DEAD: begin
                    if (press) begin
                        PipeX0 <= X0_INIT;
                        PipeX1 <= X1_INIT;
                        GapY0  <= GAP_BASE;
                        GapY1  <= GAP_BASE;
                        Score  <= 8'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed bench for pipe_scheduler: one instance at default geometry with
// STEP_DIV=4, one compact instance for double-wrap and score saturation.
module tb_pipe_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, btn1, col1;
    logic [15:0] x0a, x1a, g0a, g1a;
    logic        sta, goa, tka;
    logic [7:0]  sca;

    logic        rst2, btn2, col2;
    logic [15:0] x0b, x1b, g0b, g1b;
    logic        stb, gob, tkb;
    logic [7:0]  scb;

    pipe_scheduler #(.STEP_DIV(4)) u_dut (
        .clk(clk), .Reset(rst1), .Button(btn1), .Collision(col1),
        .PipeX0(x0a), .PipeX1(x1a), .GapY0(g0a), .GapY1(g1a),
        .Status(sta), .GameOver(goa), .Score(sca), .StepTick(tka)
    );

    pipe_scheduler #(.STEP_DIV(2), .WRAP_X(110), .INIT_X0(103), .PIPE_SPACING(0)) u_dut2 (
        .clk(clk), .Reset(rst2), .Button(btn2), .Collision(col2),
        .PipeX0(x0b), .PipeX1(x1b), .GapY0(g0b), .GapY1(g1b),
        .Status(stb), .GameOver(gob), .Score(scb), .StepTick(tkb)
    );

    // Reference LFSRs; pg* holds the gap value of the cycle before the last edge.
    logic [15:0] lfa, lfb, pga, pgb;
    always @(posedge clk) begin
        if (!rst1) lfa <= 16'hACE1;
        else       lfa <= {lfa[14:0], lfa[15] ^ lfa[13] ^ lfa[12] ^ lfa[10]};
        pga <= 16'd40 + {9'd0, lfa[6:0]};
        if (!rst2) lfb <= 16'hACE1;
        else       lfb <= {lfb[14:0], lfb[15] ^ lfb[13] ^ lfb[12] ^ lfb[10]};
        pgb <= 16'd40 + {9'd0, lfb[6:0]};
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ticks;
    logic [15:0] eg0, eg1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic go(input int k);
        while (cyc < k) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        rst1 = 1'b0; btn1 = 1'b1; col1 = 1'b0;
        rst2 = 1'b0; btn2 = 1'b1; col2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_x0", x0a, 960);
        chk("rst_x1", x1a, 1280);
        chk("rst_g0", g0a, 40);
        chk("rst_g1", g1a, 40);
        chk("rst_score", sca, 0);
        chk("rst_status", sta, 0);
        chk("rst_gameover", goa, 0);
        chk("rst_tick", tka, 0);
        rst1 = 1'b1;

        // Idle for 100 cycles: nothing moves, no ticks.
        ticks = 0;
        repeat (100) begin
            @(negedge clk);
            if (tka) ticks++;
        end
        chk("idle_ticks", ticks, 0);
        chk("idle_x0", x0a, 960);
        chk("idle_x1", x1a, 1280);
        chk("idle_status", sta, 0);

        // Start: press takes effect at edge 3, Status at edge 4, step s at edge 3+4s.
        btn1 = 1'b0; cyc = 0;
        go(3);
        chk("start_status_lag", sta, 0);
        chk("start_g0", g0a, pga);
        go(4);
        chk("start_status", sta, 1);
        chk("start_g1", g1a, pga);
        go(5);
        chk("tick_early", tka, 0);
        go(6);
        chk("tick_first", tka, 1);
        go(7);
        chk("step1_x0", x0a, 959);
        chk("step1_x1", x1a, 1279);
        chk("step1_tick", tka, 0);
        go(3 + 4 * 10);
        chk("step10_x0", x0a, 950);
        chk("step10_x1", x1a, 1270);
        btn1 = 1'b1;

        // Scoring on slot 0 and its wrap.
        go(3 + 4 * 859);
        chk("pre_score_x0", x0a, 101);
        chk("pre_score", sca, 0);
        go(3 + 4 * 860);
        chk("score_x0", x0a, 100);
        chk("score_1", sca, 1);
        go(3 + 4 * 960);
        chk("x0_zero", x0a, 0);
        go(3 + 4 * 961);
        chk("wrap0_x0", x0a, 640);
        chk("wrap0_x1", x1a, 319);
        chk("wrap0_g0", g0a, pga);
        eg0 = pga;
        go(3 + 4 * 1180);
        chk("score_2_x1", x1a, 100);
        chk("score_2", sca, 2);
        go(3 + 4 * 1281);
        chk("wrap1_x1", x1a, 640);
        chk("wrap1_x0", x0a, 320);
        chk("wrap1_g1", g1a, pga);
        chk("wrap1_g0_hold", g0a, eg0);
        eg1 = pga;

        // Collision coincident with a tick: no movement, DEAD.
        go(3 + 4 * 1282 - 1);
        chk("col_tick", tka, 1);
        col1 = 1'b1;
        go(3 + 4 * 1282);
        chk("col_x0", x0a, 320);
        chk("col_x1", x1a, 640);
        chk("col_score", sca, 2);
        go(3 + 4 * 1282 + 1);
        chk("col_gameover", goa, 1);
        chk("col_status", sta, 0);
        ticks = 0;
        repeat (20) begin
            @(negedge clk); cyc++;
            col1 = ~col1;
            if (tka) ticks++;
        end
        col1 = 1'b0;
        chk("dead_ticks", ticks, 0);
        chk("dead_x0", x0a, 320);
        chk("dead_x1", x1a, 640);
        chk("dead_g0", g0a, eg0);
        chk("dead_g1", g1a, eg1);
        chk("dead_score", sca, 2);
        chk("dead_gameover", goa, 1);

        // Held press in DEAD: exactly one transition to IDLE.
        btn1 = 1'b0; cyc = 0;
        go(3);
        chk("restart_x0", x0a, 960);
        chk("restart_x1", x1a, 1280);
        chk("restart_g0", g0a, 40);
        chk("restart_g1", g1a, 40);
        chk("restart_score", sca, 0);
        go(4);
        chk("restart_gameover", goa, 0);
        chk("restart_status", sta, 0);
        go(50);
        chk("held_status", sta, 0);
        chk("held_x0", x0a, 960);
        btn1 = 1'b1;
        go(54);

        // Reset asserted mid-RUN.
        btn1 = 1'b0; cyc = 0;
        go(3 + 4 * 5);
        chk("run2_x0", x0a, 955);
        chk("run2_status", sta, 1);
        rst1 = 1'b0;
        go(3 + 4 * 5 + 1);
        chk("midrst_x0", x0a, 960);
        chk("midrst_x1", x1a, 1280);
        chk("midrst_status", sta, 0);
        chk("midrst_g0", g0a, 40);
        rst1 = 1'b1; btn1 = 1'b1;

        // Second instance: equal slots, double wrap and score saturation.
        chk("b_rst_x0", x0b, 103);
        chk("b_rst_x1", x1b, 103);
        rst2 = 1'b1;
        @(negedge clk);
        btn2 = 1'b0; cyc = 0;
        go(3 + 2 * 2);
        chk("b_pre_x0", x0b, 101);
        chk("b_pre_score", scb, 0);
        go(3 + 2 * 3);
        chk("b_x0_100", x0b, 100);
        chk("b_x1_100", x1b, 100);
        chk("b_score_plus2", scb, 2);
        btn2 = 1'b1;
        go(3 + 2 * 103);
        chk("b_zero_x0", x0b, 0);
        chk("b_zero_x1", x1b, 0);
        go(3 + 2 * 104);
        chk("b_wrap_x0", x0b, 110);
        chk("b_wrap_x1_delay", x1b, 0);
        chk("b_wrap_g0", g0b, pgb);
        go(3 + 2 * 104 + 1);
        chk("b_wrap_x1", x1b, 110);
        chk("b_wrap_g1", g1b, pgb);
        go(3 + 2 * (3 + 111 * 126));
        chk("b_score_254", scb, 254);
        go(3 + 2 * (3 + 111 * 127));
        chk("b_score_sat", scb, 255);
        go(3 + 2 * (3 + 111 * 128));
        chk("b_score_hold", scb, 255);
        chk("b_x0_period", x0b, 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
